// File: rtl/clint.sv
// Core-local interrupt source: mtime/mtimecmp/msip registers on a single-cycle slave port
// plus a prioritised interrupt request held until acknowledged. Macro CLINT_MTIME_WR_EN makes MTIME writable.
module clint #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned XMSB     = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic          req_wr,
  input  logic [15:0]   req_addr,
  input  logic [XMSB:0] req_wdata,
  output logic          rsp_valid,
  output logic [XMSB:0] rsp_rdata,
  input  logic          meip,
  input  logic          glb_ie,
  input  logic [XMSB:0] mie,
  output logic          mtip,
  output logic          msip,
  output logic          irq_req,
  output logic [XMSB:0] irq_cause,
  input  logic          irq_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [XMSB:0] CAUSE_MEI = {1'b1, XMSB'(11)};
  localparam logic [XMSB:0] CAUSE_MSI = {1'b1, XMSB'(3)};
  localparam logic [XMSB:0] CAUSE_MTI = {1'b1, XMSB'(7)};

  logic [15:0]   r_presc;
  logic [XMSB:0] r_mtime;
  logic [XMSB:0] r_mtimecmp;
  logic          r_msip;
  logic          r_mtip;
  logic          r_rsp_valid;
  logic [XMSB:0] r_rsp_rdata;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [XMSB:0] r_cause;
  logic [XMSB:0] w_cause_nxt;

  logic          w_tick;
  logic          w_wr;
  logic          w_sel_msip;
  logic          w_sel_cmp;
  logic          w_sel_time;
  logic [XMSB:0] w_rdata;
  logic          w_mei;
  logic          w_msi;
  logic          w_mti;
  logic          w_unused;

  // Only MSIE/MTIE/MEIE and the 8-byte-aligned address bits matter.
  assign w_unused = ^{mie[XMSB:12], mie[10:8], mie[6:4], mie[2:0], req_addr[2:0]};

  assign w_tick     = (r_presc == 16'(TICK_DIV - 1));
  assign w_wr       = req_valid & req_wr;
  assign w_sel_msip = (req_addr[15:3] == 13'h0000);
  assign w_sel_cmp  = (req_addr[15:3] == 13'h0800);
  assign w_sel_time = (req_addr[15:3] == 13'h17FF);

  always_comb begin
    w_rdata = '0;
    if (w_sel_msip)      w_rdata = {{XMSB{1'b0}}, r_msip};
    else if (w_sel_cmp)  w_rdata = r_mtimecmp;
    else if (w_sel_time) w_rdata = r_mtime;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_msip      <= 1'b0;
      r_mtip      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_presc     <= w_tick ? 16'd0 : r_presc + 16'd1;
      r_rsp_valid <= req_valid;
      r_rsp_rdata <= (req_valid && !req_wr) ? w_rdata : '0;
      r_mtip      <= (r_mtime >= r_mtimecmp);
      if (w_wr && w_sel_msip) r_msip     <= req_wdata[0];
      if (w_wr && w_sel_cmp)  r_mtimecmp <= req_wdata;
`ifdef CLINT_MTIME_WR_EN
      // A write in the same cycle as a tick wins outright; the prescaler keeps running.
      if (w_wr && w_sel_time) r_mtime <= req_wdata;
      else if (w_tick)        r_mtime <= r_mtime + 1'b1;
`else
      if (w_tick)             r_mtime <= r_mtime + 1'b1;
`endif
    end
  end

  assign w_mei = meip   & mie[11] & glb_ie;
  assign w_msi = r_msip & mie[3]  & glb_ie;
  assign w_mti = r_mtip & mie[7]  & glb_ie;

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    case (r_state)
      S_IDLE: begin
        if (w_mei || w_msi || w_mti) begin
          w_state_nxt = S_REQ;
          w_cause_nxt = w_mei ? CAUSE_MEI : (w_msi ? CAUSE_MSI : CAUSE_MTI);
        end
      end
      S_REQ:   if (irq_ack) w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cause <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // Request is decoded straight from state so reset drops it asynchronously.
  assign irq_req   = (r_state == S_REQ);
  assign irq_cause = r_cause;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign mtip      = r_mtip;
  assign msip      = r_msip;

endmodule
